// File: rtl/button_event_pkg.sv
// Shared definitions for the button gesture classifier: FSM state encoding,
// default clock rate and a constant helper.
package button_event_pkg;

   localparam int unsigned CLK_FREQ_DEFAULT = 95_000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRESSED = 3'd1,
      ST_WAIT2   = 3'd2,
      ST_SECOND  = 3'd3,
      ST_LONG    = 3'd4
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_ms_tick.sv
// Free-running millisecond prescaler: tick is high for one clk cycle each time
// the counter wraps from CLK_FREQ-1 back to 0.
module ms_tick
   import button_event_pkg::*;
#(
   parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

   logic [PW-1:0] presc_q;

   assign tick = (presc_q == PW'(CLK_FREQ - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

endmodule

// File: rtl/button_event.sv
// Classifies debounced button gestures into single click, double click or long
// press, emitting one registered one-cycle pulse per gesture.
module button_event
   import button_event_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = CLK_FREQ_DEFAULT,
   parameter int unsigned LONG_PRESS_MS = 1000,
   parameter int unsigned DCLICK_MS     = 300
) (
   input  logic clk,
   input  logic rst,
   input  logic button_valid,
   output logic click,
   output logic dclick,
   output logic long_press,
   output logic held
);

   localparam int unsigned MAX_MS = max_u(LONG_PRESS_MS, DCLICK_MS);
   localparam int unsigned CW     = $clog2(MAX_MS + 1);

   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_PRESS_MS - 1);
   localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_MS - 1);
   localparam logic [CW-1:0] MS_SAT      = CW'(MAX_MS);

   logic          tick;
   logic          btn_q;
   logic          rise, fall;
   state_e        state_q, state_d;
   logic [CW-1:0] ms_cnt_q, ms_cnt_d;
   logic          click_q, click_d;
   logic          dclick_q, dclick_d;
   logic          long_q, long_d;
   logic          held_q, held_d;

   ms_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   assign rise = button_valid & ~btn_q;
   assign fall = ~button_valid & btn_q;

   // Edges are tested before timeouts so an edge wins on the expiring tick.
   always_comb begin
      state_d  = state_q;
      click_d  = 1'b0;
      dclick_d = 1'b0;
      long_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (fall) begin
               state_d = ST_WAIT2;
            end else if (tick && ms_cnt_q == LONG_LAST) begin
               state_d = ST_LONG;
               long_d  = 1'b1;
            end
         end
         ST_WAIT2: begin
            if (rise) begin
               state_d = ST_SECOND;
            end else if (tick && ms_cnt_q == DCLICK_LAST) begin
               state_d = ST_IDLE;
               click_d = 1'b1;
            end
         end
         ST_SECOND: begin
            if (fall) begin
               state_d  = ST_IDLE;
               dclick_d = 1'b1;
            end else if (tick && ms_cnt_q == LONG_LAST) begin
               state_d  = ST_LONG;
               dclick_d = 1'b1;
            end
         end
         ST_LONG: begin
            if (fall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
         ms_cnt_d = '0;
      end else if (tick && ms_cnt_q != MS_SAT) begin
         ms_cnt_d = ms_cnt_q + 1'b1;
      end else begin
         ms_cnt_d = ms_cnt_q;
      end

      held_d = (state_d inside {ST_PRESSED, ST_SECOND, ST_LONG});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         ms_cnt_q <= '0;
         btn_q    <= 1'b0;
         click_q  <= 1'b0;
         dclick_q <= 1'b0;
         long_q   <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ms_cnt_q <= ms_cnt_d;
         btn_q    <= button_valid;
         click_q  <= click_d;
         dclick_q <= dclick_d;
         long_q   <= long_d;
         held_q   <= held_d;
      end
   end

   assign click      = click_q;
   assign dclick     = dclick_q;
   assign long_press = long_q;
   assign held       = held_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: stimulus queues expected pulses with a
// cycle window, a monitor pops and checks every pulse the DUT produces.
module tb_button_event;

   localparam int unsigned CLK_FREQ = 10;
   localparam int unsigned LONG_MS  = 20;
   localparam int unsigned DCLK_MS  = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic button_valid = 1'b0;
   logic click, dclick, long_press, held;

   always #5 clk = ~clk;

   button_event #(
      .CLK_FREQ     (CLK_FREQ),
      .LONG_PRESS_MS(LONG_MS),
      .DCLICK_MS    (DCLK_MS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .button_valid(button_valid),
      .click       (click),
      .dclick      (dclick),
      .long_press  (long_press),
      .held        (held)
   );

   typedef enum int {EV_CLICK = 0, EV_DCLICK = 1, EV_LONG = 2} ev_e;
   typedef struct {
      ev_e kind;
      int  lo;
      int  hi;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int presc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Independent ms reference used only to place the edge-vs-timeout stimulus.
   always @(posedge clk or negedge rst) begin
      if (!rst) presc <= 0;
      else      presc <= (presc == int'(CLK_FREQ) - 1) ? 0 : presc + 1;
   end

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // A timeout of n ms entered by an edge driven in cycle p lands between
   // (n-1) and n ms later, depending on the free-running prescaler phase.
   task automatic expect_timeout(input ev_e k, input int p, input int n_ms);
      exp_t e;
      e.kind = k;
      e.lo   = p + int'(CLK_FREQ) * n_ms - (int'(CLK_FREQ) - 2);
      e.hi   = p + int'(CLK_FREQ) * n_ms + 1;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      int   npulse;
      ev_e  k;
      exp_t e;
      if (rst) begin
         npulse = int'(click) + int'(dclick) + int'(long_press);
         if (npulse > 1) begin
            check("pulse_onehot", npulse, 1);
         end else if (npulse == 1) begin
            k = click ? EV_CLICK : (dclick ? EV_DCLICK : EV_LONG);
            if (sb.size() == 0) begin
               check("unexpected_pulse_kind", int'(k), -1);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", int'(k), int'(e.kind));
               n_vec++;
               if (cyc < e.lo || cyc > e.hi) begin
                  n_err++;
                  $display("FAIL pulse_time: pulse at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d expected pulses pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ticks;

      step(3);
      check("reset_outputs", int'({click, dclick, long_press, held}), 0);
      rst = 1'b1;
      step(5);

      // 1: single click
      button_valid = 1'b1;
      step(30);
      check("s1_held_pressed", int'(held), 1);
      button_valid = 1'b0;
      expect_timeout(EV_CLICK, cyc, DCLK_MS);
      step(100);
      check("s1_drained", sb.size(), 0);

      // 2: double click, pulse one cycle after the second fall
      button_valid = 1'b1;
      step(20);
      button_valid = 1'b0;
      step(20);
      button_valid = 1'b1;
      step(20);
      button_valid = 1'b0;
      sb.push_back('{EV_DCLICK, cyc + 1, cyc + 1});
      step(100);
      check("s2_drained", sb.size(), 0);

      // 3: long press, held drops one cycle after release, no release pulse
      button_valid = 1'b1;
      expect_timeout(EV_LONG, cyc, LONG_MS);
      step(150);
      check("s3_held_mid", int'(held), 1);
      step(150);
      button_valid = 1'b0;
      @(negedge clk);
      check("s3_held_at_fall", int'(held), 1);
      @(negedge clk);
      check("s3_held_after_fall", int'(held), 0);
      step(100);
      check("s3_drained", sb.size(), 0);

      // 4: click then a long second press -> dclick only
      button_valid = 1'b1;
      step(20);
      button_valid = 1'b0;
      step(20);
      button_valid = 1'b1;
      expect_timeout(EV_DCLICK, cyc, LONG_MS);
      step(250);
      check("s4_held_long", int'(held), 1);
      button_valid = 1'b0;
      step(100);
      check("s4_drained", sb.size(), 0);

      // 5: reset mid-hold, button still down on release of reset
      button_valid = 1'b1;
      step(100);
      check("s5_held_before_rst", int'(held), 1);
      rst = 1'b0;
      #1;
      check("s5_rst_outputs", int'({click, dclick, long_press, held}), 0);
      step(20);
      check("s5_rst_outputs_hold", int'({click, dclick, long_press, held}), 0);
      rst = 1'b1;
      expect_timeout(EV_LONG, cyc, LONG_MS);
      step(250);
      button_valid = 1'b0;
      step(100);
      check("s5_drained", sb.size(), 0);

      // 6: release lands on the expiring 20th tick -> WAIT2, then click
      button_valid = 1'b1;
      ticks = 0;
      for (int i = 0; i < 400 && ticks < int'(LONG_MS); i++) begin
         step(1);
         if (presc == int'(CLK_FREQ) - 1) ticks++;
      end
      check("s6_tick_found", ticks, int'(LONG_MS));
      button_valid = 1'b0;
      expect_timeout(EV_CLICK, cyc, DCLK_MS);
      @(negedge clk);
      @(negedge clk);
      check("s6_held_after_fall", int'(held), 0);
      step(100);
      check("s6_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
